gold_descrambler: RTL and testbench

//  Receive-side consumer of the Gold sequence c(n) = x1(n+1600) ^ x2(n+1600) (TS 38.211 5.2.1).
//  - Drives an external x2_seq_gen and generates x1 internally.
//  - XORs c(n) onto a W-bit-per-beat hard-bit stream with valid/ready flow control.
//  - Descrambles one PUCCH codeword of i_len bits per i_start, between demodulator and decoder.

---
 rtl/gold_descrambler.sv | 211 +++++++++++++++++++++
 tb/tb_gold_descrambler.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gold_descrambler.sv
// Gold-sequence descrambler: drives an external x2 generator, runs x1 locally,
// and XORs c(n) onto a W-bit valid/ready stream for one codeword per start.
module gold_descrambler #(
    parameter int W     = 8,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [30:0]      i_c_init,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_x2_load,
    output logic             o_x2_en,
    output logic [30:0]      o_x2_init,
    input  logic [W-1:0]     i_x2_seq,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W-1:0]     s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [W-1:0]     m_data,
    output logic             m_last,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PRIME,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // Row k is x^(1600+k) mod (x^31 + x^3 + 1): the x1 taps for output bit k.
    function automatic logic [W-1:0][30:0] x1_masks();
        logic [31:0]           p;
        logic [W-1:0][30:0]    m;
        p = 32'd1;
        m = '0;
        for (int i = 0; i < 1600; i++) begin
            p = p << 1;
            if (p[31]) begin
                p = p ^ 32'h8000_0009;
            end
        end
        for (int k = 0; k < W; k++) begin
            m[k] = p[30:0];
            p = p << 1;
            if (p[31]) begin
                p = p ^ 32'h8000_0009;
            end
        end
        return m;
    endfunction

    localparam logic [W-1:0][30:0] X1_MASK = x1_masks();
    localparam logic [LEN_W:0]     W_L     = (LEN_W + 1)'(W);
    localparam logic [LEN_W:0]     W_M1    = (LEN_W + 1)'(W - 1);

    state_t           state_q;
    state_t           state_d;
    logic [30:0]      c_init_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W:0]   rem_q;
    logic [30:0]      x1_q;
    logic [30:0]      x1_nxt;
    logic [W-1:0]     x1_word;
    logic [W-1:0]     x1_par;
    logic [W-1:0]     tail_keep;
    logic [LEN_W:0]   len_ext;
    logic [LEN_W:0]   beats_ext;
    logic [LEN_W:0]   rem_ext;
    logic             beat_in;
    logic             last_beat;

    assign len_ext   = {1'b0, i_len};
    assign beats_ext = (len_ext + W_M1) / W_L;
    assign rem_ext   = len_ext % W_L;
    assign last_beat = (cnt_q == LEN_W'(1));
    assign o_x2_init = c_init_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = (i_len == '0) ? DONE : LOAD;
                end
            end
            LOAD:  state_d = PRIME;
            PRIME: state_d = RUN;
            RUN: begin
                if (beat_in && last_beat) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (m_valid && m_ready) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control outputs; x2/x1 advance only on PRIME or an accepted beat.
    always_comb begin
        o_x2_load = 1'b0;
        s_ready   = 1'b0;
        beat_in   = 1'b0;
        o_x2_en   = 1'b0;
        o_busy    = (state_q != IDLE);
        o_done    = (state_q == DONE);
        unique case (state_q)
            LOAD:  o_x2_load = 1'b1;
            PRIME: o_x2_en   = 1'b1;
            RUN: begin
                s_ready = !m_valid || m_ready;
                beat_in = s_valid && s_ready;
                o_x2_en = beat_in;
            end
            default: begin
                o_x2_load = 1'b0;
            end
        endcase
    end

    // Codeword context: c_init, remaining beats and tail remainder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_init_q <= '0;
            cnt_q    <= '0;
            rem_q    <= '0;
        end else if (state_q == IDLE && i_start) begin
            c_init_q <= i_c_init;
            cnt_q    <= beats_ext[LEN_W-1:0];
            rem_q    <= rem_ext;
        end else if (beat_in) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // x1 state stepped W positions ahead.
    always_comb begin
        x1_nxt = x1_q;
        for (int i = 0; i < W; i++) begin
            x1_nxt = {x1_nxt[3] ^ x1_nxt[0], x1_nxt[30:1]};
        end
    end

    // Parallel x1 word: bit k = x1(n+1600+k) of the current state.
    always_comb begin
        x1_par = '0;
        for (int k = 0; k < W; k++) begin
            x1_par[k] = ^(x1_q & X1_MASK[k]);
        end
    end

    // x1 generator; word register moves in lockstep with x2_seq_gen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x1_q    <= '0;
            x1_word <= '0;
        end else if (state_q == LOAD) begin
            x1_q <= 31'h1;
        end else if (o_x2_en) begin
            x1_q    <= x1_nxt;
            x1_word <= x1_par;
        end
    end

    // Bits past the codeword end in the final beat are zeroed.
    always_comb begin
        tail_keep = '1;
        if (last_beat && rem_q != '0) begin
            for (int k = 0; k < W; k++) begin
                tail_keep[k] = ((LEN_W + 1)'(k) < rem_q);
            end
        end
    end

    // Single output register; holds while the sink stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else if (beat_in) begin
            m_valid <= 1'b1;
            m_data  <= (s_data ^ i_x2_seq ^ x1_word) & tail_keep;
            m_last  <= last_beat;
        end else if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gold_descrambler.sv
// Directed bench for gold_descrambler with a behavioural x2_seq_gen and
// a golden c(n) built by stepping both LFSRs bit by bit.
module tb_gold_descrambler;

    localparam int W     = 8;
    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_start;
    logic [30:0]      i_c_init;
    logic [LEN_W-1:0] i_len;
    logic             o_x2_load;
    logic             o_x2_en;
    logic [30:0]      o_x2_init;
    logic [W-1:0]     i_x2_seq;
    logic             s_valid;
    logic             s_ready;
    logic [W-1:0]     s_data;
    logic             m_valid;
    logic             m_ready;
    logic [W-1:0]     m_data;
    logic             m_last;
    logic             o_busy;
    logic             o_done;

    bit         din [0:2047];
    bit         cg  [0:2047];
    bit         orig[0:63];
    logic [W:0] sb[$];
    int         checks = 0;
    int         errors = 0;
    int         en_cnt = 0;
    int         load_cnt = 0;
    int         mv_cnt = 0;
    logic [30:0] x2_ci;
    int          x2_pos;

    always #5 clk = ~clk;

    gold_descrambler #(.W(W), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (i_start),
        .i_c_init  (i_c_init),
        .i_len     (i_len),
        .o_x2_load (o_x2_load),
        .o_x2_en   (o_x2_en),
        .o_x2_init (o_x2_init),
        .i_x2_seq  (i_x2_seq),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .o_busy    (o_busy),
        .o_done    (o_done)
    );

    function automatic bit x2_bit(input logic [30:0] ci, input int idx);
        logic [30:0] b;
        b = ci;
        for (int i = 0; i < idx; i++) begin
            b = {b[3] ^ b[2] ^ b[1] ^ b[0], b[30:1]};
        end
        return b[0];
    endfunction

    // Behavioural x2_seq_gen.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_x2_seq <= '0;
            x2_ci    <= '0;
            x2_pos   <= 0;
        end else if (o_x2_load) begin
            x2_ci  <= o_x2_init;
            x2_pos <= 0;
        end else if (o_x2_en) begin
            for (int k = 0; k < W; k++) begin
                i_x2_seq[k] <= x2_bit(x2_ci, 1600 + x2_pos + k);
            end
            x2_pos <= x2_pos + W;
        end
    end

    always @(posedge clk) begin
        if (o_x2_en)   en_cnt   <= en_cnt + 1;
        if (o_x2_load) load_cnt <= load_cnt + 1;
        if (m_valid)   mv_cnt   <= mv_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_c(input logic [30:0] ci, input int n);
        logic [30:0] a;
        logic [30:0] b;
        a = 31'h1;
        b = ci;
        for (int i = 0; i < 1600 + n; i++) begin
            if (i >= 1600) cg[i-1600] = a[0] ^ b[0];
            a = {a[3] ^ a[0], a[30:1]};
            b = {b[3] ^ b[2] ^ b[1] ^ b[0], b[30:1]};
        end
    endtask

    task automatic run_cw(input logic [30:0] ci, input int len, input bit stall,
                          input int abort_after, input bit poke);
        int         nb;
        int         sent;
        int         got;
        int         en0;
        int         ld0;
        int         idx;
        bit         fin;
        bit         last_got;
        logic [W-1:0] e;
        logic [W:0] q;
        nb = (len + W - 1) / W;
        fill_c(ci, nb * W);
        en0 = en_cnt;
        ld0 = load_cnt;
        sent = 0;
        got = 0;
        fin = 0;
        last_got = 0;
        sb.delete();
        i_c_init = ci;
        i_len = LEN_W'(len);
        i_start = 1'b1;
        @(negedge clk);
        i_c_init = ~ci;
        i_len = LEN_W'(3);
        for (int cyc = 0; cyc < 5000 && !fin; cyc++) begin
            i_start = poke && cyc == 3;
            s_valid = (sent < nb) && (!stall || $urandom_range(1) == 1);
            for (int k = 0; k < W; k++) s_data[k] = din[sent * W + k];
            m_ready = !stall || $urandom_range(1) == 1;
            #1;
            if (cyc == 0) check("x2_load", {o_x2_load, o_x2_en}, 2'b10);
            if (cyc == 1) check("x2_prime", {o_x2_load, o_x2_en}, 2'b01);
            if (cyc == 2) check("first_ready", s_ready, 1);
            if (last_got) begin
                check("done_pulse", o_done, 1);
                fin = 1;
            end else begin
                if (s_valid && s_ready) begin
                    for (int k = 0; k < W; k++) begin
                        idx = sent * W + k;
                        e[k] = (idx < len) ? (din[idx] ^ cg[idx]) : 1'b0;
                    end
                    sb.push_back({sent == nb - 1, e});
                    sent++;
                end
                if (m_valid && m_ready) begin
                    check("sb_nonempty", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        q = sb.pop_front();
                        check("m_data", m_data, q[W-1:0]);
                        check("m_last", m_last, q[W]);
                    end
                    got++;
                    if (got == nb) last_got = 1;
                    if (abort_after > 0 && got == abort_after) begin
                        rst_n = 1'b0;
                        #1;
                        check("rst_ctrl", {m_valid, s_ready, o_busy, o_x2_en,
                                           o_x2_load, o_done, m_last}, 0);
                        check("rst_data", m_data, 0);
                        sb.delete();
                        s_valid = 1'b0;
                        i_start = 1'b0;
                        @(negedge clk);
                        rst_n = 1'b1;
                        @(negedge clk);
                        return;
                    end
                end
            end
            @(negedge clk);
        end
        check("no_timeout", fin, 1);
        check("x2_en_count", en_cnt - en0, nb + 1);
        check("x2_load_count", load_cnt - ld0, 1);
        i_start = 1'b0;
        s_valid = 1'b0;
        #1;
        check("back_idle", {o_busy, o_done}, 0);
    endtask

    initial begin
        int en0;
        int ld0;
        int mv0;
        rst_n = 1'b0;
        i_start = 1'b0;
        i_c_init = '0;
        i_len = '0;
        s_valid = 1'b0;
        s_data = '0;
        m_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {o_x2_load, o_x2_en, s_ready, m_valid, m_last,
                             o_busy, o_done}, 0);
        check("reset_data", {m_data, o_x2_init}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: all-zero input yields c(0..63) itself.
        for (int i = 0; i < 2048; i++) din[i] = 1'b0;
        run_cw(31'h0, 64, 1'b0, 0, 1'b0);

        // 2: pre-scrambled 40 bits come back as the originals.
        fill_c(31'h12345678, 40);
        for (int i = 0; i < 40; i++) begin
            orig[i] = 1'($urandom_range(1));
            din[i] = orig[i] ^ cg[i];
        end
        run_cw(31'h12345678, 40, 1'b0, 0, 1'b0);

        // 3: partial last beat, tail bits must be zeroed.
        for (int i = 0; i < 16; i++) din[i] = 1'($urandom_range(1));
        din[13] = 1'b1;
        din[14] = 1'b1;
        din[15] = 1'b1;
        run_cw(31'h0ABCDEF1, 13, 1'b0, 0, 1'b0);

        // 4: len=200 without and with random stalls.
        for (int i = 0; i < 200; i++) din[i] = 1'($urandom_range(1));
        run_cw(31'h2468ACE, 200, 1'b0, 0, 1'b0);
        run_cw(31'h2468ACE, 200, 1'b1, 0, 1'b0);

        // 5: zero-length codeword.
        en0 = en_cnt;
        ld0 = load_cnt;
        mv0 = mv_cnt;
        i_len = '0;
        i_c_init = 31'h55;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        #1;
        check("len0_done", {o_done, o_busy}, 2'b11);
        @(negedge clk);
        #1;
        check("len0_idle", {o_done, o_busy}, 2'b00);
        check("len0_no_en", en_cnt - en0, 0);
        check("len0_no_load", load_cnt - ld0, 0);
        check("len0_no_mvalid", mv_cnt - mv0, 0);

        // 6: reset mid-run, then a clean run with a start poked while busy.
        for (int i = 0; i < 64; i++) din[i] = 1'($urandom_range(1));
        run_cw(31'h5, 64, 1'b0, 3, 1'b0);
        run_cw(31'h1, 16, 1'b0, 0, 1'b1);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
